// File: rtl/hazard_controller_if.sv
// Bundle of ID-stage hazard inputs and pipeline control outputs for hazard_controller.
// master: pipeline side (drives ID fields, consumes controls). slave: the controller.
interface hazard_controller_if #(
  parameter int unsigned STALL_CNT_W = 16
);
  logic                   id_valid;
  logic [4:0]             id_rs;
  logic [4:0]             id_rt;
  logic                   id_uses_rs;
  logic                   id_uses_rt;
  logic                   id_reg_write;
  logic [4:0]             id_write_reg;
  logic                   id_mem_read;
  logic                   ex_branch_taken;

  logic                   pc_write;
  logic                   if_id_write;
  logic                   if_id_flush;
  logic                   id_ex_bubble;
  logic [1:0]             fwd_a_sel;
  logic [1:0]             fwd_b_sel;
  logic [STALL_CNT_W-1:0] stall_count;
  logic                   busy;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write, id_write_reg,
           id_mem_read, ex_branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a_sel, fwd_b_sel,
           stall_count, busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write, id_write_reg,
           id_mem_read, ex_branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a_sel, fwd_b_sel,
           stall_count, busy
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the ID stage of a 5-stage pipeline.
// Tracks in-flight writers in a private EX/MEM/WB scoreboard, stalls on RAW hazards,
// flushes IF/ID after taken branches and drives EX operand-forwarding selects.
// Optional feature macro: FORWARDING_EN (forwarding selects + load-use-only stalls).
// Without it, forwarding selects are tied to 00 and ID stalls until writers leave MEM.
// The interface instance must be built with the same STALL_CNT_W as this module.
module hazard_controller #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input logic                clk,
  input logic                reset,
  hazard_controller_if.slave hc
);

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [4:0] dest;
    logic       mem_read;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
  } sb_slot_t;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } state_e;

  sb_slot_t               ex_q, mem_q, wb_q, id_slot;
  state_e                 state_q;
  logic [2:0]             flush_cnt_q;
  logic                   busy_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic                   hazard;
  logic                   stall_cyc;
  logic [1:0]             fwd_a, fwd_b;
  logic                   id_use_rs, id_use_rt;

  // True when slot s will write register r that the reader actually uses; r0 never matches.
  function automatic logic writes(sb_slot_t s, logic [4:0] r, logic used);
    return used & s.valid & s.reg_write & (s.dest != 5'd0) & (s.dest == r);
  endfunction

  assign id_use_rs = hc.id_valid & hc.id_uses_rs;
  assign id_use_rt = hc.id_valid & hc.id_uses_rt;

  // Capture the ID instruction in scoreboard-slot form.
  always_comb begin
    id_slot          = '0;
    id_slot.valid    = hc.id_valid;
    id_slot.reg_write = hc.id_reg_write;
    id_slot.dest     = hc.id_write_reg;
    id_slot.mem_read = hc.id_mem_read;
    id_slot.rs       = hc.id_rs;
    id_slot.rt       = hc.id_rt;
    id_slot.uses_rs  = hc.id_uses_rs;
    id_slot.uses_rt  = hc.id_uses_rt;
  end

`ifdef FORWARDING_EN
  // Only a load still in EX cannot be forwarded in time.
  assign hazard = ex_q.mem_read &
                  (writes(ex_q, hc.id_rs, id_use_rs) | writes(ex_q, hc.id_rt, id_use_rt));

  // Forwarding selects for the EX instruction; the younger MEM result wins over WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (writes(mem_q, ex_q.rs, ex_q.valid & ex_q.uses_rs))     fwd_a = 2'b01;
    else if (writes(wb_q, ex_q.rs, ex_q.valid & ex_q.uses_rs)) fwd_a = 2'b10;
    if (writes(mem_q, ex_q.rt, ex_q.valid & ex_q.uses_rt))     fwd_b = 2'b01;
    else if (writes(wb_q, ex_q.rt, ex_q.valid & ex_q.uses_rt)) fwd_b = 2'b10;
  end
`else
  // No bypass: wait until every pending writer has reached WB.
  assign hazard = writes(ex_q,  hc.id_rs, id_use_rs) | writes(ex_q,  hc.id_rt, id_use_rt) |
                  writes(mem_q, hc.id_rs, id_use_rs) | writes(mem_q, hc.id_rt, id_use_rt);
  assign fwd_a  = 2'b00;
  assign fwd_b  = 2'b00;
`endif

  // Slot fields not consumed by the selected hazard/forwarding logic.
  logic unused_sb;
  assign unused_sb = ^{ex_q, mem_q, wb_q};

  // Pipeline control: reset > branch > flush tail > hazard stall > normal.
  always_comb begin
    hc.pc_write     = 1'b1;
    hc.if_id_write  = 1'b1;
    hc.if_id_flush  = 1'b0;
    hc.id_ex_bubble = 1'b0;
    stall_cyc       = 1'b0;
    if (reset) begin
      hc.pc_write     = 1'b0;
      hc.if_id_write  = 1'b0;
      hc.if_id_flush  = 1'b1;
      hc.id_ex_bubble = 1'b1;
    end else if (hc.ex_branch_taken || (state_q == StFlush)) begin
      hc.if_id_flush  = 1'b1;
      hc.id_ex_bubble = 1'b1;
    end else if (hazard) begin
      hc.pc_write     = 1'b0;
      hc.if_id_write  = 1'b0;
      hc.id_ex_bubble = 1'b1;
      stall_cyc       = 1'b1;
    end
    hc.fwd_a_sel = reset ? 2'b00 : fwd_a;
    hc.fwd_b_sel = reset ? 2'b00 : fwd_b;
  end

  assign hc.busy        = busy_q;
  assign hc.stall_count = stall_cnt_q;

  // Scoreboard shift, stall counter and RUN/STALL/FLUSH state with registered busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= StRun;
      flush_cnt_q <= 3'd0;
      busy_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= (hc.id_ex_bubble || !hc.id_valid) ? '0 : id_slot;

      if (stall_cyc && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end

      if (hc.ex_branch_taken) begin
        // The branch cycle itself is the first flush cycle; FLUSH covers the rest.
        flush_cnt_q <= 3'(FLUSH_CYCLES - 1);
        if (FLUSH_CYCLES > 1) begin
          state_q <= StFlush;
          busy_q  <= 1'b1;
        end else begin
          state_q <= StRun;
          busy_q  <= 1'b0;
        end
      end else begin
        unique case (state_q)
          StRun: begin
            if (hazard) begin
              state_q <= StStall;
              busy_q  <= 1'b1;
            end
          end
          StStall: begin
            if (!hazard) begin
              state_q <= StRun;
              busy_q  <= 1'b0;
            end
          end
          StFlush: begin
            if (flush_cnt_q <= 3'd1) begin
              flush_cnt_q <= 3'd0;
              state_q     <= StRun;
              busy_q      <= 1'b0;
            end else begin
              flush_cnt_q <= flush_cnt_q - 3'd1;
            end
          end
          default: begin
            state_q <= StRun;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
